skew_inbuf: RTL and testbench
=============================

SKEW_INBUF -- requirements
Module: skew_inbuf

Interface
REQ-001 Parameters SHALL be:
- WORDLEN, 8, bits per lane word.
- LANES, 4, parallel lanes, 1..16.
- DEPTH, 16, entries per lane, 2..32.
- SKEW, 1, extra padding words per lane index.
- Legal only if (LANES-1)*SKEW < DEPTH.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous clear to the reset state.
- wr_en  in  1  write request.
- wr_data  in  LANES*WORDLEN  lane k at bits [k*WORDLEN +: WORDLEN].
- wr_ready  out  1  write will be accepted.
- rd_en  in  1  read request.
- rd_data  out  LANES*WORDLEN  head word of each lane, same packing.
- rd_valid  out  1  read will be accepted.
- level  out  clog2(DEPTH+1)  occupancy of lane 0.
- err_ovf  out  1  sticky, a write was dropped.
- err_udf  out  1  sticky, a read was ignored.

Function
REQ-003 Each lane SHALL be a circular FIFO of DEPTH words with its own head pointer, tail pointer and count.
REQ-004 After reset or flush, lane k SHALL hold k*SKEW zero padding words ahead of user data; this produces the diagonal systolic skew.
REQ-005 wr_ready SHALL be 1 when the count of lane LANES-1 is less than DEPTH.
REQ-006 rd_valid SHALL be 1 when the count of lane 0 is greater than 0.
REQ-007 Lane 0 always has the lowest count and lane LANES-1 the highest, so REQ-005 and REQ-006 gate all lanes together.
REQ-008 A write SHALL occur when wr_en and wr_ready are both 1 at the edge; it stores one word per lane at that lane's tail, and all tails advance.
REQ-009 A read SHALL occur when rd_en and rd_valid are both 1 at the edge; all heads advance.
REQ-010 Pointers SHALL wrap from DEPTH-1 to 0, with no dead slot; all DEPTH entries are usable.
REQ-011 rd_data SHALL be combinational from the lane heads when rd_valid=1, and all-zero when rd_valid=0.
REQ-012 Write latency SHALL be one cycle: data written at edge N appears at a lane head after edge N when that lane was empty.
REQ-013 wr_ready and rd_valid SHALL depend only on registered state, never on rd_en or wr_en in the same cycle. At full, a same-cycle read does not make wr_ready=1.
REQ-014 With a simultaneous read and write both accepted, every count SHALL be unchanged and both pointers SHALL advance.
REQ-015 A write with wr_ready=0 SHALL be dropped with no state change, and err_ovf SHALL be set.
REQ-016 A read with rd_valid=0 SHALL be ignored, and err_udf SHALL be set.
REQ-017 err_ovf and err_udf SHALL clear only on reset or flush.
REQ-018 flush SHALL take priority over same-cycle rd_en and wr_en. It restores the REQ-019 state on the next edge, and err_* clear.
REQ-019 Reset SHALL act asynchronously on rstn=0 and restore:
- lane k: head=0, tail=k*SKEW mod DEPTH, count=k*SKEW, padding entries zero;
- level=0, rd_valid=0, wr_ready=1, err_ovf=0, err_udf=0, rd_data=0.
REQ-020 Reset release SHALL be sampled at a clock edge; the first write can be accepted at the first edge with rstn=1.
REQ-021 Assertion of rstn mid-operation SHALL discard all contents immediately, independent of clk.

Verification (LANES=4, DEPTH=8, SKEW=1, WORDLEN=8)
REQ-022 Skew: after reset, write vectors A=(lane3..0)=0x13,0x12,0x11,0x10, then B=0x23..0x20, then two 0x00 vectors, and read 4 times -> rd_data lanes (3..0) are:
- read 1: 00,00,00,10
- read 2: 00,00,11,20
- read 3: 00,12,21,00
- read 4: 13,22,00,00
REQ-023 Full: after reset, 5 writes -> wr_ready=0, level=5. A 6th write is dropped and err_ovf=1. The next 5 reads return the 5 written lane-0 words.
REQ-024 Empty: after reset, rd_en=1 for 1 cycle -> err_udf=1, level=0, pointers unchanged.
REQ-025 Simultaneous at full: with lane 3 count=8, apply rd_en=1 and wr_en=1 together -> read accepted and write dropped (err_ovf=1); next cycle wr_ready=1 and level=4.
REQ-026 Wrap: 40 back-to-back read+write pairs at level=3 -> output order equals input order delayed per lane, with no loss and no duplication.
REQ-027 Flush and reset: flush, and separately rstn=0 between edges, mid-stream at level=4 -> state equals REQ-019 (level=0, lane-3 count=3) on the next edge for flush and immediately for rstn.

Source files
------------

// File: rtl/skew_inbuf.sv
// Multi-lane input buffer: one circular FIFO per lane, with lane k pre-loaded with k*SKEW zero
// words so that lanes leave the buffer diagonally skewed, as a systolic array expects.
module skew_inbuf #(
    parameter int unsigned WORDLEN = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned SKEW    = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [LANES*WORDLEN-1:0]     wr_data,
    output logic                         wr_ready,
    input  logic                         rd_en,
    output logic [LANES*WORDLEN-1:0]     rd_data,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         err_ovf,
    output logic                         err_udf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (LANES < 1 || LANES > 16 || DEPTH < 2 || DEPTH > 32 ||
        (LANES - 1) * SKEW >= DEPTH) begin : g_bad_params
        $error("skew_inbuf: illegal parameter combination");
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [LANES-1:0][WORDLEN-1:0] head_word;
    logic [CW-1:0]                 cnt_first;
    logic [CW-1:0]                 cnt_last;
    logic                          do_wr;
    logic                          do_rd;
    logic                          err_ovf_q;
    logic                          err_udf_q;

    // Lane 0 always holds the fewest words and the last lane the most, so these two counts
    // gate every lane at once.
    assign wr_ready = (cnt_last < CW'(DEPTH));
    assign rd_valid = (cnt_first != '0);
    assign do_wr    = wr_en & wr_ready;
    assign do_rd    = rd_en & rd_valid;
    assign level    = cnt_first;
    assign rd_data  = rd_valid ? head_word : '0;
    assign err_ovf  = err_ovf_q;
    assign err_udf  = err_udf_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned PadWords = k * SKEW;
        localparam logic [PW-1:0] TailInit = PW'(PadWords % DEPTH);
        localparam logic [CW-1:0] CntInit  = CW'(PadWords);

        logic [DEPTH-1:0][WORDLEN-1:0] mem_q;
        logic [PW-1:0]                 head_q;
        logic [PW-1:0]                 tail_q;
        logic [CW-1:0]                 cnt_q;

        // Clearing the whole array makes the padding slots read as zero after reset or flush.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                mem_q  <= '0;
                head_q <= '0;
                tail_q <= TailInit;
                cnt_q  <= CntInit;
            end else if (flush) begin
                mem_q  <= '0;
                head_q <= '0;
                tail_q <= TailInit;
                cnt_q  <= CntInit;
            end else begin
                if (do_wr) begin
                    mem_q[tail_q] <= wr_data[k*WORDLEN +: WORDLEN];
                    tail_q        <= ptr_inc(tail_q);
                end
                if (do_rd) begin
                    head_q <= ptr_inc(head_q);
                end
                if (do_wr && !do_rd) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (do_rd && !do_wr) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end

        assign head_word[k] = mem_q[head_q];

        if (k == 0) begin : g_first
            assign cnt_first = cnt_q;
        end
        if (k == LANES - 1) begin : g_last
            assign cnt_last = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else if (flush) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (wr_en && !wr_ready) begin
                err_ovf_q <= 1'b1;
            end
            if (rd_en && !rd_valid) begin
                err_udf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_skew_inbuf.sv
// Self-checking bench for skew_inbuf: per-lane queue scoreboard plus fixed scenario vectors.
module tb_skew_inbuf;

    localparam int WL = 8;
    localparam int LN = 4;
    localparam int DP = 8;
    localparam int SK = 1;
    localparam int DW = WL * LN;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          wr_ready;
    logic          rd_valid;
    logic          err_ovf;
    logic          err_udf;
    logic [3:0]    level;

    int checks = 0;
    int errors = 0;

    logic [WL-1:0] mq [LN][$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    skew_inbuf #(
        .WORDLEN (WL),
        .LANES   (LN),
        .DEPTH   (DP),
        .SKEW    (SK)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level),
        .err_ovf  (err_ovf),
        .err_udf  (err_udf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int k = 0; k < LN; k++) begin
            mq[k].delete();
            for (int j = 0; j < k * SK; j++) mq[k].push_back('0);
        end
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Called at posedge+1; drives one cycle and returns the sampled and predicted rd_data.
    task automatic tick(input logic w, input logic [DW-1:0] d, input logic r,
                        output logic [DW-1:0] got, output logic [DW-1:0] expv);
        logic wa, ra;
        wr_en = w;
        wr_data = d;
        rd_en = r;
        #1;
        got = rd_data;
        expv = '0;
        ra = (mq[0].size() > 0);
        wa = (mq[LN-1].size() < DP);
        if (ra) for (int k = 0; k < LN; k++) expv[k*WL +: WL] = mq[k][0];
        if (r && ra) for (int k = 0; k < LN; k++) void'(mq[k].pop_front());
        if (w && wa) for (int k = 0; k < LN; k++) mq[k].push_back(d[k*WL +: WL]);
        if (w && !wa) m_ovf = 1'b1;
        if (r && !ra) m_udf = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [DW-1:0] g, e;
        #1;
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        checks++; if ({err_ovf, err_udf} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {err_ovf, err_udf}); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        tick(1'b1, 32'hDEADBEEF, 1'b0, g, e);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL first_write_level: got %0d expected 1", level); end
    endtask

    task automatic test_skew();
        logic [DW-1:0] g, e;
        logic [DW-1:0] tbl [4];
        tbl[0] = 32'h00000010;
        tbl[1] = 32'h00001120;
        tbl[2] = 32'h00122100;
        tbl[3] = 32'h13220000;
        do_reset();
        tick(1'b1, 32'h13121110, 1'b0, g, e);
        tick(1'b1, 32'h23222120, 1'b0, g, e);
        tick(1'b1, 32'h00000000, 1'b0, g, e);
        tick(1'b1, 32'h00000000, 1'b0, g, e);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b1, g, e);
            checks++; if (g !== tbl[i]) begin errors++; $display("FAIL skew_read%0d: got %h expected %h", i + 1, g, tbl[i]); end
            checks++; if (g !== e) begin errors++; $display("FAIL skew_model%0d: got %h expected %h", i + 1, g, e); end
        end
    endtask

    task automatic test_full();
        logic [DW-1:0] g, e, d;
        logic [WL-1:0] w0 [5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            w0[i] = d[WL-1:0];
            tick(1'b1, d, 1'b0, g, e);
        end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL full_level: got %0d expected 5", level); end
        tick(1'b1, 32'hFFFFFFFF, 1'b0, g, e);
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL full_err_ovf: got %b expected 1", err_ovf); end
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL full_drop_level: got %0d expected 5", level); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, '0, 1'b1, g, e);
            checks++; if (g[WL-1:0] !== w0[i]) begin errors++; $display("FAIL full_lane0_%0d: got %h expected %h", i, g[WL-1:0], w0[i]); end
            checks++; if (g !== e) begin errors++; $display("FAIL full_model%0d: got %h expected %h", i, g, e); end
        end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", level); end
        checks++; if (err_ovf !== m_ovf) begin errors++; $display("FAIL full_ovf_sticky: got %b expected %b", err_ovf, m_ovf); end
    endtask

    task automatic test_empty();
        logic [DW-1:0] g, e;
        do_reset();
        tick(1'b0, '0, 1'b1, g, e);
        checks++; if (err_udf !== 1'b1) begin errors++; $display("FAIL empty_err_udf: got %b expected 1", err_udf); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL empty_level: got %0d expected 0", level); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL empty_rd_valid: got %b expected 0", rd_valid); end
        tick(1'b1, 32'hA4A3A2A1, 1'b0, g, e);
        tick(1'b0, '0, 1'b1, g, e);
        checks++; if (g !== 32'h000000A1) begin errors++; $display("FAIL empty_ptrs: got %h expected 000000a1", g); end
        checks++; if (err_udf !== m_udf) begin errors++; $display("FAIL empty_udf_sticky: got %b expected %b", err_udf, m_udf); end
    endtask

    task automatic test_simul_full();
        logic [DW-1:0] g, e;
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0, g, e);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL simul_pre_ready: got %b expected 0", wr_ready); end
        tick(1'b1, 32'h55555555, 1'b1, g, e);
        checks++; if (g !== e) begin errors++; $display("FAIL simul_read: got %h expected %h", g, e); end
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL simul_err_ovf: got %b expected 1", err_ovf); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL simul_wr_ready: got %b expected 1", wr_ready); end
        checks++; if (level !== 4'd4) begin errors++; $display("FAIL simul_level: got %0d expected 4", level); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] g, e;
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, $urandom, 1'b0, g, e);
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, $urandom, 1'b1, g, e);
            checks++; if (g !== e) begin errors++; $display("FAIL wrap_pair%0d: got %h expected %h", i, g, e); end
        end
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL wrap_level: got %0d expected 3", level); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, 1'b1, g, e);
            checks++; if (g !== e) begin errors++; $display("FAIL wrap_drain%0d: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic fill_to_four();
        logic [DW-1:0] g, e;
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b1, $urandom, 1'b0, g, e);
        tick(1'b0, '0, 1'b1, g, e);
    endtask

    task automatic check_fresh(input string tag);
        logic [DW-1:0] g, e;
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL %s_level: got %0d expected 0", tag, level); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL %s_rd_valid: got %b expected 0", tag, rd_valid); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL %s_wr_ready: got %b expected 1", tag, wr_ready); end
        checks++; if ({err_ovf, err_udf} !== 2'b00) begin errors++; $display("FAIL %s_err: got %b expected 00", tag, {err_ovf, err_udf}); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL %s_rd_data: got %h expected 0", tag, rd_data); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] g, e;
        fill_to_four();
        checks++; if (level !== 4'd4) begin errors++; $display("FAIL flush_pre_level: got %0d expected 4", level); end
        flush = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 32'h77777777;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_reset();
        check_fresh("flush");
        for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0, g, e);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL flush_lane3_count: got %b expected 0", wr_ready); end
        tick(1'b0, '0, 1'b1, g, e);
        checks++; if (g !== e) begin errors++; $display("FAIL flush_read: got %h expected %h", g, e); end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] g, e;
        fill_to_four();
        #2;
        rstn = 1'b0;
        #1;
        check_fresh("arst");
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0, g, e);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL arst_lane3_count: got %b expected 0", wr_ready); end
        tick(1'b0, '0, 1'b1, g, e);
        checks++; if (g !== e) begin errors++; $display("FAIL arst_read: got %h expected %h", g, e); end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_full();
        test_empty();
        test_simul_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
